rom_word_fetcher: RTL and testbench

ROM_WORD_FETCHER -- requirements
Module: rom_word_fetcher

---
 rtl/rom_word_fetcher.sv | 116 +++++++++++
 tb/tb_rom_word_fetcher.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rom_word_fetcher.sv
// Sequential ROM word fetcher feeding a serial data converter.
// Walks addresses 0..WORD_COUNT-1, one word per downstream request.
module rom_word_fetcher #(
    parameter int ROM_DATA_WIDTH = 96,
    parameter int ADDR_WIDTH     = 5,
    parameter int WORD_COUNT     = 32,
    parameter bit WRAP           = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      ready_read_i,
    input  logic [ROM_DATA_WIDTH-1:0] rom_q_i,
    output logic [ADDR_WIDTH-1:0]     rom_addr_o,
    output logic [ROM_DATA_WIDTH-1:0] rom_data_o,
    output logic                      data_valid_o,
    output logic                      busy_o,
    output logic                      done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [ROM_DATA_WIDTH-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      armed_q, armed_d;

    logic start_acc;
    logic req_acc;
    logic last_word;

    assign start_acc = start_i && (state_q == IDLE || state_q == DONE);
    assign req_acc   = (state_q == HOLD) && ready_read_i && armed_q;
    assign last_word = (addr_q == LAST_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_acc) state_d = ISSUE;
            ISSUE:      state_d = CAPTURE;
            CAPTURE:    state_d = HOLD;
            HOLD: begin
                if (req_acc) begin
                    state_d = (last_word && !WRAP) ? DONE : ISSUE;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        armed_d = armed_q;
        if (start_acc) begin
            addr_d  = '0;
            armed_d = 1'b0;
        end
        if (state_q == CAPTURE) begin
            data_d  = rom_q_i;
            valid_d = 1'b1;
        end
        if (req_acc) begin
            valid_d = 1'b0;
            armed_d = 1'b0;
            if (!last_word) begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end else if (WRAP) begin
                addr_d = '0;
            end
        end
        // A low request level always re-arms, so a held-high level counts once.
        if (!ready_read_i) armed_d = 1'b1;
        busy_d = (state_d == ISSUE) || (state_d == CAPTURE) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    assign rom_addr_o   = addr_q;
    assign rom_data_o   = data_q;
    assign data_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_rom_word_fetcher.sv
// Scoreboard bench: a stop-at-end instance and a wrapping instance
// share one stimulus stream; captured words are checked by a monitor.
module tb_rom_word_fetcher;

    localparam int DW = 96;
    localparam int AW = 5;
    localparam int WC = 4;

    logic clk = 1'b0;
    logic rst, start, ready;
    logic [DW-1:0] q0, q1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic valid0, valid1, busy0, busy1, done0, done1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];

    always #5 clk = ~clk;

    rom_word_fetcher #(.ROM_DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                       .WORD_COUNT(WC), .WRAP(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ready_read_i(ready),
        .rom_q_i(q0), .rom_addr_o(addr0), .rom_data_o(data0),
        .data_valid_o(valid0), .busy_o(busy0), .done_o(done0));

    rom_word_fetcher #(.ROM_DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                       .WORD_COUNT(WC), .WRAP(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ready_read_i(ready),
        .rom_q_i(q1), .rom_addr_o(addr1), .rom_data_o(data1),
        .data_valid_o(valid1), .busy_o(busy1), .done_o(done1));

    // Synchronous ROM models: q = 500 + addr
    always @(posedge clk) begin
        q0 <= DW'(500) + DW'(addr0);
        q1 <= DW'(500) + DW'(addr1);
    end

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: each new word presented (valid rising) pops one expectation.
    logic pv0 = 1'b0;
    logic pv1 = 1'b0;
    always @(negedge clk) begin
        if (valid0 === 1'b1 && pv0 !== 1'b1) begin
            if (exp0.size() == 0) begin
                check("dut0 unexpected word", data0, '1);
            end else begin
                check("dut0 word", data0, exp0.pop_front());
            end
        end
        if (valid1 === 1'b1 && pv1 !== 1'b1) begin
            if (exp1.size() == 0) begin
                check("dut1 unexpected word", data1, '1);
            end else begin
                check("dut1 word", data1, exp1.pop_front());
            end
        end
        pv0 = valid0;
        pv1 = valid1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        tick(2);
        check("rst data0", data0, 0);
        check("rst valid0", DW'(valid0), 0);
        check("rst addr0", DW'(addr0), 0);
        check("rst busy0", DW'(busy0), 0);
        check("rst done0", DW'(done0), 0);
        check("rst data1", data1, 0);

        // First word two edges after start
        rst = 1'b0;
        exp0.push_back(DW'(500));
        exp1.push_back(DW'(500));
        pulse_start();
        tick(1);
        check("issue->capture valid0", DW'(valid0), 0);
        check("issue->capture busy0", DW'(busy0), 1);
        tick(1);
        check("first data0", data0, DW'(500));
        check("first valid0", DW'(valid0), 1);
        check("first busy0", DW'(busy0), 1);

        exp0.push_back(DW'(501)); exp1.push_back(DW'(501));
        pulse_ready();
        check("addr0 after 1st req", DW'(addr0), 1);
        exp0.push_back(DW'(502)); exp1.push_back(DW'(502));
        pulse_ready();
        check("data0 after 2nd req", data0, DW'(502));

        // start ignored while in HOLD
        pulse_start();
        tick(3);
        check("start in HOLD addr0", DW'(addr0), 2);
        check("start in HOLD data0", data0, DW'(502));

        // Level held high: exactly one advance
        exp0.push_back(DW'(503)); exp1.push_back(DW'(503));
        ready = 1'b1;
        tick(10);
        check("held-high addr0", DW'(addr0), 3);
        check("held-high data0", data0, DW'(503));
        check("held-high valid0", DW'(valid0), 1);
        ready = 1'b0;
        tick(1);

        // Last word: stop vs wrap
        exp1.push_back(DW'(500));
        pulse_ready();
        check("end done0", DW'(done0), 1);
        check("end busy0", DW'(busy0), 0);
        check("end data0", data0, DW'(503));
        check("end valid0", DW'(valid0), 0);
        check("wrap addr1", DW'(addr1), 0);
        check("wrap data1", data1, DW'(500));
        check("wrap done1", DW'(done1), 0);

        // Restart from DONE; wrapping instance ignores start in HOLD
        exp0.push_back(DW'(500));
        pulse_start();
        tick(3);
        check("restart data0", data0, DW'(500));
        check("restart done0", DW'(done0), 0);
        check("ignored start addr1", DW'(addr1), 0);

        // Reset while in CAPTURE at address 2
        exp0.push_back(DW'(501)); exp1.push_back(DW'(501));
        pulse_ready();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        check("pre-rst addr0", DW'(addr0), 2);
        check("pre-rst valid0", DW'(valid0), 0);
        rst = 1'b1;
        tick(1);
        check("mid rst data0", data0, 0);
        check("mid rst addr0", DW'(addr0), 0);
        check("mid rst busy0", DW'(busy0), 0);
        check("mid rst data1", data1, 0);
        check("mid rst busy1", DW'(busy1), 0);
        rst = 1'b0;
        exp0.push_back(DW'(500)); exp1.push_back(DW'(500));
        pulse_start();
        tick(2);
        check("post-rst data0", data0, DW'(500));
        check("post-rst data1", data1, DW'(500));

        for (int i = 0; i < 20; i++) begin
            if (exp0.size() == 0 && exp1.size() == 0) break;
            tick(1);
        end
        check("dut0 pending words", DW'(exp0.size()), 0);
        check("dut1 pending words", DW'(exp1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
